// File: rtl/booth_mult.sv
// Radix-2 Booth sequential signed multiplier.
// Produces a 2*DATA_WIDTH product into Hi/Lo over DATA_WIDTH+1 cycles.
module booth_mult #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  MultCtrl,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo,
  output logic                  MultBusy,
  output logic                  MultDone
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W:0]      m;
  logic [2*W+1:0]  p;
  logic [CW-1:0]   count;
  logic [W:0]      upper;
  logic [W:0]      sum;
  logic [2*W+1:0]  p_shift;
  logic            last;

  assign upper    = p[2*W+1:W+1];
  assign last     = (count == CW'(W-1));
  assign MultBusy = (state != IDLE);

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after W steps
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (MultCtrl) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One Booth step: add/sub M per P[1:0], then arithmetic shift right
  always_comb begin
    sum = upper;
    unique case (p[1:0])
      2'b01:   sum = upper + m;
      2'b10:   sum = upper - m;
      default: sum = upper;
    endcase
    p_shift = {sum[W], sum, p[W:1]};
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Datapath: latch operands, iterate, publish product
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m        <= '0;
      p        <= '0;
      count    <= '0;
      Hi       <= '0;
      Lo       <= '0;
      MultDone <= 1'b0;
    end else begin
      MultDone <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (MultCtrl) begin
            m     <= {A[W-1], A};
            p     <= {{(W+1){1'b0}}, B, 1'b0};
            count <= '0;
          end
        end
        RUN: begin
          p     <= p_shift;
          count <= count + CW'(1);
        end
        DONE: begin
          Hi <= p[2*W:W+1];
          Lo <= p[W:1];
        end
        default: ;
      endcase
    end
  end

endmodule
